alu_rr_scheduler: RTL

//  Shares one ALU instance (module ALU, WIDTH passed through) between N_REQ requesters.

---
 rtl/alu_pkg.sv | 15 +
 rtl/ALU.sv | 53 +++++
 rtl/rr_arbiter.sv | 29 ++
 rtl/alu_rr_scheduler.sv | 118 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state definitions shared by the ALU scheduler slice
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/ALU.sv
// rtl/ALU.sv - combinational add/sub/and/or unit; zero/carry outputs only when ALU_FLAGS_EN is defined
module ALU
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
`ifdef ALU_FLAGS_EN
    output logic             zero,
    output logic             carry,
`endif
    output logic [WIDTH-1:0] result
);

    // One extra bit holds add carry-out / sub borrow when flags are built.
`ifdef ALU_FLAGS_EN
    localparam int XW = WIDTH + 1;
`else
    localparam int XW = WIDTH;
`endif

    logic [XW-1:0] sum;
    logic [XW-1:0] diff;

    assign sum  = XW'(a) + XW'(b);
    assign diff = XW'(a) - XW'(b);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = sum[WIDTH-1:0];
            OP_SUB:  result = diff[WIDTH-1:0];
            OP_AND:  result = a & b;
            default: result = a | b;
        endcase
    end

`ifdef ALU_FLAGS_EN
    always_comb begin
        carry = 1'b0;
        case (op)
            OP_ADD:  carry = sum[WIDTH];
            OP_SUB:  carry = diff[WIDTH];
            default: carry = 1'b0;
        endcase
    end

    assign zero = (result == '0);
`endif

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request at or above ptr, wrapping
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id
);

    always_comb begin
        logic found;
        int   idx;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_id      = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin sharing of one ALU across N_REQ requesters, one op in flight
// Optional zero/carry response flags are built when ALU_FLAGS_EN is defined.
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*2-1:0]     req_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
`ifdef ALU_FLAGS_EN
    output logic                   rsp_zero,
    output logic                   rsp_carry,
`endif
    output logic [WIDTH-1:0]       rsp_result
);

    state_t           state_q;
    state_t           state_d;
    logic [ID_W-1:0]  rr_ptr;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_code;
    logic [ID_W-1:0]  op_id;
    logic [WIDTH-1:0] alu_result;
`ifdef ALU_FLAGS_EN
    logic             alu_zero;
    logic             alu_carry;
`endif

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    ALU #(.WIDTH(WIDTH)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (op_code),
`ifdef ALU_FLAGS_EN
        .zero   (alu_zero),
        .carry  (alu_carry),
`endif
        .result (alu_result)
    );

    // Grant is offered only in IDLE and never while reset is asserted.
    assign req_ready = (state_q == S_IDLE && !rst) ? gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|req_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_valid && rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= OP_ADD;
            op_id      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
`ifdef ALU_FLAGS_EN
            rsp_zero   <= 1'b0;
            rsp_carry  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (|req_valid) begin
                    op_a    <= req_a[int'(gnt_id)*WIDTH +: WIDTH];
                    op_b    <= req_b[int'(gnt_id)*WIDTH +: WIDTH];
                    op_code <= req_op[int'(gnt_id)*2 +: 2];
                    op_id   <= gnt_id;
                end
                S_EXEC: begin
                    rsp_valid  <= 1'b1;
                    rsp_id     <= op_id;
                    rsp_result <= alu_result;
`ifdef ALU_FLAGS_EN
                    rsp_zero   <= alu_zero;
                    rsp_carry  <= alu_carry;
`endif
                end
                S_RESP: if (rsp_valid && rsp_ready) begin
                    rsp_valid <= 1'b0;
                    rr_ptr    <= (op_id == ID_W'(N_REQ-1)) ? '0 : op_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
